ps2_keyboard_matrix: RTL and testbench
======================================

# ps2_keyboard_matrix

Converts a PS/2 keyboard (scan code set 2) into the C64 8×8 keyboard matrix, which CIA1's port pins read. It sits directly upstream of CIA1. CIA1 `pa_out` (column strobes, active low) and `pb_out` (row strobes) drive in. The block answers on CIA1 `pb_in` / `pa_in`. RESTORE, which is not part of the matrix, is output separately for the NMI logic.

## Interface
- `TIMEOUT`, default 20000: idle `clk` cycles after which a partial PS/2 frame is abandoned.
- `clk`  in  1: system clock, same clock as the CIA. Reset is synchronous and active-high.
- `res`  in  1: synchronous, active-high reset.
- `ps2_clk`  in  1: raw PS/2 clock, asynchronous to `clk`.
- `ps2_data`  in  1: raw PS/2 data, asynchronous to `clk`.
- `pa_out`  in  8: CIA1 port A output. Bit c low selects column c.
- `pb_out`  in  8: CIA1 port B output. Bit r low selects row r, for reverse scanning.
- `pb_in`  out  8: to CIA1 port B input. Row r reads low if any selected column has key (c,r) down.
- `pa_in`  out  8: to CIA1 port A input. Column c reads low if any selected row has key (c,r) down.
- `restore`  out  1: high while RESTORE (PC PageUp) is held.

## Operation
- **Input synchronisation:** 2-flop synchroniser on `ps2_clk` and `ps2_data`. Then a 3-sample majority filter on the clock. A falling edge of the filtered clock is the bit strobe.
- **Frame receiver:** bit counter 0..10 covering start(0), d0..d7 (LSB first), odd parity, stop(1).
  - A start bit sampled as 1 aborts: counter stays 0.
  - On stop, the byte is accepted only if stop=1 and the 9 bits d0..d7,parity have odd weight. Otherwise it is discarded, and the `brk` and `ext` flags are cleared.
  - Idle counter: cleared on each strobe, saturates at `TIMEOUT`. Reaching `TIMEOUT` with counter ≠ 0 resets the counter to 0.
- **Decoder:** state flags `brk` and `ext`, acted on per accepted byte.
  - F0 sets `brk`. E0 sets `ext`.
  - AA (BAT) clears all 64 matrix bits, `restore`, and both flags.
  - Any other byte is looked up as {ext, byte} in a combinational map giving (c,r) or "unmapped". Key (c,r) is set if `brk`=0, cleared if `brk`=1. Both flags then clear.
  - Unmapped codes only clear the flags.
- **Required map entries:**
  - 1C A → (1,2)
  - 12 LShift → (1,7)
  - 59 RShift → (6,4)
  - 29 Space → (7,4)
  - 5A Return → (0,1)
  - 66 Backspace → (0,0)
  - 76 Esc → RUN/STOP (7,7)
  - 05 F1 → (0,4)
  - 14 LCtrl → CTRL (7,2)
  - 11 LAlt → C= (7,5)
  - E0 74 → CRSR RT (0,2)
  - E0 72 → CRSR DN (0,7)
  - E0 7D → `restore` (not in matrix)
  - All remaining letters, digits and punctuation map to the C64 key with the same legend, at its standard matrix position.
- **Matrix:** 64-bit register `key[c][r]`, 1 = pressed.
  - `pb_in[r]` = NOT OR over c of (~`pa_out[c]` & `key[c][r]`).
  - `pa_in[c]` = NOT OR over r of (~`pb_out[r]` & `key[c][r]`).
  - No ghosting emulation.

## Timing
- **Reset:** `pb_in`=FF, `pa_in`=FF, `restore`=0. Matrix, flags, bit counter and idle counter are all 0. Reset mid-frame discards the partial frame.
- **Strobe latency:** 3 `clk` from a raw `ps2_clk` falling edge (2 synchroniser + 1 filter/edge).
- **Matrix update:** `key` / `restore` update on the `clk` after the stop-bit strobe. `pb_in` / `pa_in` reflect the change one further `clk` later.
- **Scan response:** `pb_in` and `pa_in` are registered. A change on `pa_out` / `pb_out` appears 1 `clk` later, inside the CIA's read window.
- **Simultaneous events:** an AA clear and a scan change in the same cycle give the cleared result. Repeated make codes (typematic) for a held key are idempotent.

## Test plan
- **Reset:** assert `res` for 2 clk with `pa_out`=00 → `pb_in`=FF, `pa_in`=FF, `restore`=0.
- **Make, scan, break for A:** send 1C, then set `pa_out`=FD → `pb_in`=FB; set `pa_out`=FF → `pb_in`=FF. Send F0 1C, then `pa_out`=FD → `pb_in`=FF.
- **Two keys, both scan directions:** send 12 then 29, then `pa_out`=7D → `pb_in`=6F. Set `pb_out`=EF, `pa_out`=FF → `pa_in`=7F.
- **Extended codes:** send E0 7D → `restore`=1; send E0 F0 7D → 0. Send E0 72, then `pa_out`=FE → `pb_in`=7F.
- **Errors:** send 1C with bad parity → no key set. Send a frame truncated after 5 bits, then idle > `TIMEOUT` clk, then a valid 5A, then `pa_out`=FE → `pb_in`=FD.
- **BAT and reset mid-frame:** hold 5 keys, send AA → all scans read FF. Assert `res` after bit 4 of a frame; the next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_keyboard_matrix_if.sv
// PS/2 keyboard lines plus CIA1 port A/B scan bus, with RESTORE for the NMI logic.
// The master side is the keyboard/CIA, and the slave side is the matrix emulator.
interface ps2_keyboard_matrix_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] pa_out;
  logic [7:0] pb_out;
  logic [7:0] pb_in;
  logic [7:0] pa_in;
  logic       restore;

  modport master (
    output ps2_clk, ps2_data, pa_out, pb_out,
    input  pb_in, pa_in, restore
  );

  modport slave (
    input  ps2_clk, ps2_data, pa_out, pb_out,
    output pb_in, pa_in, restore
  );
endinterface

// File: rtl/ps2_keyboard_matrix.sv
// PS/2 set-2 keyboard to C64 8x8 matrix, read by CIA1 ports A/B.
// key[c][r] is indexed by port A bit (column) c and port B bit (row) r.
module ps2_keyboard_matrix #(
  parameter int TIMEOUT = 20000
) (
  input logic                  clk,
  input logic                  res,
  ps2_keyboard_matrix_if.slave bus
);

  localparam int            IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] TO = IW'(TIMEOUT);

  // ---------------- input sync / filter ----------------
  logic [1:0] pclk_s, pdat_s;
  logic [1:0] pclk_h;
  logic       pclk_f;
  logic       pclk_maj;
  logic       strobe;
  logic       pdat;

  assign pclk_maj = (pclk_s[1] & pclk_h[0]) | (pclk_s[1] & pclk_h[1]) | (pclk_h[0] & pclk_h[1]);
  // Strobe as the filtered clock is about to drop; data is stable mid-low-phase.
  assign strobe   = pclk_f & ~pclk_maj;
  assign pdat     = pdat_s[1];

  // Two-flop synchronisers, plus a short history feeding the majority filter; idle lines are high.
  always_ff @(posedge clk) begin
    if (res) begin
      pclk_s <= 2'b11;
      pdat_s <= 2'b11;
      pclk_h <= 2'b11;
      pclk_f <= 1'b1;
    end else begin
      pclk_s <= {pclk_s[0], bus.ps2_clk};
      pdat_s <= {pdat_s[0], bus.ps2_data};
      pclk_h <= {pclk_h[0], pclk_s[1]};
      pclk_f <= pclk_maj;
    end
  end

  // ---------------- frame receiver ----------------
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [IW-1:0] idle;
  logic          rx_vld, rx_err;
  logic [7:0]    rx_byte;

  // Bit counter 0..10; the idle timeout abandons a stalled partial frame.
  always_ff @(posedge clk) begin
    if (res) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      idle    <= '0;
      rx_vld  <= 1'b0;
      rx_err  <= 1'b0;
      rx_byte <= '0;
    end else begin
      rx_vld <= 1'b0;
      rx_err <= 1'b0;
      if (strobe) begin
        idle <= '0;
        if (bit_cnt == 4'd0) begin
          if (!pdat) bit_cnt <= 4'd1;
        end else if (bit_cnt <= 4'd8) begin
          shreg   <= {pdat, shreg[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd9) begin
          par     <= pdat;
          bit_cnt <= 4'd10;
        end else begin
          bit_cnt <= 4'd0;
          if (pdat && ^{shreg, par}) begin
            rx_vld  <= 1'b1;
            rx_byte <= shreg;
          end else begin
            rx_err <= 1'b1;
          end
        end
      end else begin
        if (idle != TO) idle <= idle + IW'(1);
        if (idle == TO && bit_cnt != 4'd0) bit_cnt <= 4'd0;
      end
    end
  end

  // ---------------- decoder ----------------
  logic       brk, ext;
  logic [7:0] key [8];
  logic       restore_q;
  logic [7:0] map_out;          // {hit, is_restore, c[2:0], r[2:0]}
  logic       map_hit, map_rst;
  logic [2:0] map_c, map_r;

  // Combinational {ext, code} -> matrix position lookup.
  always_comb begin
    map_out = 8'h00;
    case ({ext, rx_byte})
      9'h066: map_out = {2'b10, 3'd0, 3'd0};
      9'h05A: map_out = {2'b10, 3'd0, 3'd1};
      9'h174: map_out = {2'b10, 3'd0, 3'd2};
      9'h083: map_out = {2'b10, 3'd0, 3'd3};
      9'h005: map_out = {2'b10, 3'd0, 3'd4};
      9'h004: map_out = {2'b10, 3'd0, 3'd5};
      9'h003: map_out = {2'b10, 3'd0, 3'd6};
      9'h172: map_out = {2'b10, 3'd0, 3'd7};
      9'h026: map_out = {2'b10, 3'd1, 3'd0};
      9'h01D: map_out = {2'b10, 3'd1, 3'd1};
      9'h01C: map_out = {2'b10, 3'd1, 3'd2};
      9'h025: map_out = {2'b10, 3'd1, 3'd3};
      9'h01A: map_out = {2'b10, 3'd1, 3'd4};
      9'h01B: map_out = {2'b10, 3'd1, 3'd5};
      9'h024: map_out = {2'b10, 3'd1, 3'd6};
      9'h012: map_out = {2'b10, 3'd1, 3'd7};
      9'h02E: map_out = {2'b10, 3'd2, 3'd0};
      9'h02D: map_out = {2'b10, 3'd2, 3'd1};
      9'h023: map_out = {2'b10, 3'd2, 3'd2};
      9'h036: map_out = {2'b10, 3'd2, 3'd3};
      9'h021: map_out = {2'b10, 3'd2, 3'd4};
      9'h02B: map_out = {2'b10, 3'd2, 3'd5};
      9'h02C: map_out = {2'b10, 3'd2, 3'd6};
      9'h022: map_out = {2'b10, 3'd2, 3'd7};
      9'h03D: map_out = {2'b10, 3'd3, 3'd0};
      9'h035: map_out = {2'b10, 3'd3, 3'd1};
      9'h034: map_out = {2'b10, 3'd3, 3'd2};
      9'h03E: map_out = {2'b10, 3'd3, 3'd3};
      9'h032: map_out = {2'b10, 3'd3, 3'd4};
      9'h033: map_out = {2'b10, 3'd3, 3'd5};
      9'h03C: map_out = {2'b10, 3'd3, 3'd6};
      9'h02A: map_out = {2'b10, 3'd3, 3'd7};
      9'h046: map_out = {2'b10, 3'd4, 3'd0};
      9'h043: map_out = {2'b10, 3'd4, 3'd1};
      9'h03B: map_out = {2'b10, 3'd4, 3'd2};
      9'h045: map_out = {2'b10, 3'd4, 3'd3};
      9'h03A: map_out = {2'b10, 3'd4, 3'd4};
      9'h042: map_out = {2'b10, 3'd4, 3'd5};
      9'h044: map_out = {2'b10, 3'd4, 3'd6};
      9'h031: map_out = {2'b10, 3'd4, 3'd7};
      9'h079: map_out = {2'b10, 3'd5, 3'd0};   // keypad +
      9'h04D: map_out = {2'b10, 3'd5, 3'd1};
      9'h04B: map_out = {2'b10, 3'd5, 3'd2};
      9'h04E: map_out = {2'b10, 3'd5, 3'd3};
      9'h049: map_out = {2'b10, 3'd5, 3'd4};
      9'h041: map_out = {2'b10, 3'd5, 3'd7};
      9'h07C: map_out = {2'b10, 3'd6, 3'd1};   // keypad *
      9'h04C: map_out = {2'b10, 3'd6, 3'd2};
      9'h16C: map_out = {2'b10, 3'd6, 3'd3};   // Home
      9'h059: map_out = {2'b10, 3'd6, 3'd4};
      9'h055: map_out = {2'b10, 3'd6, 3'd5};
      9'h04A: map_out = {2'b10, 3'd6, 3'd7};
      9'h016: map_out = {2'b10, 3'd7, 3'd0};
      9'h014: map_out = {2'b10, 3'd7, 3'd2};
      9'h01E: map_out = {2'b10, 3'd7, 3'd3};
      9'h029: map_out = {2'b10, 3'd7, 3'd4};
      9'h011: map_out = {2'b10, 3'd7, 3'd5};
      9'h015: map_out = {2'b10, 3'd7, 3'd6};
      9'h076: map_out = {2'b10, 3'd7, 3'd7};
      9'h17D: map_out = {2'b11, 6'd0};         // PageUp -> RESTORE
      default: map_out = 8'h00;
    endcase
  end

  assign map_hit = map_out[7];
  assign map_rst = map_out[6];
  assign map_c   = map_out[5:3];
  assign map_r   = map_out[2:0];

  // Prefix flags and the key matrix advance once per accepted byte.
  always_ff @(posedge clk) begin
    if (res) begin
      brk       <= 1'b0;
      ext       <= 1'b0;
      restore_q <= 1'b0;
      for (int c = 0; c < 8; c++) key[c] <= '0;
    end else if (rx_err) begin
      brk <= 1'b0;
      ext <= 1'b0;
    end else if (rx_vld) begin
      case (rx_byte)
        8'hF0: brk <= 1'b1;
        8'hE0: ext <= 1'b1;
        8'hAA: begin
          brk       <= 1'b0;
          ext       <= 1'b0;
          restore_q <= 1'b0;
          for (int c = 0; c < 8; c++) key[c] <= '0;
        end
        default: begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (map_hit) begin
            if (map_rst) restore_q <= ~brk;
            else         key[map_c][map_r] <= ~brk;
          end
        end
      endcase
    end
  end

  // ---------------- scan ----------------
  logic [7:0] row_act, col_act;
  logic [7:0] pb_in_q, pa_in_q;

  // Forward scan (columns -> rows) and reverse scan (rows -> columns), no ghosting.
  always_comb begin
    row_act = '0;
    col_act = '0;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++) begin
        row_act[r] = row_act[r] | (~bus.pa_out[c] & key[c][r]);
        col_act[c] = col_act[c] | (~bus.pb_out[r] & key[c][r]);
      end
  end

  // Registered port answers; pull-ups read as 1 when nothing is pressed.
  always_ff @(posedge clk) begin
    if (res) begin
      pb_in_q <= 8'hFF;
      pa_in_q <= 8'hFF;
    end else begin
      pb_in_q <= ~row_act;
      pa_in_q <= ~col_act;
    end
  end

  assign bus.pb_in   = pb_in_q;
  assign bus.pa_in   = pa_in_q;
  assign bus.restore = restore_q;

endmodule

// File: tb/tb_ps2_keyboard_matrix.sv
// Directed bench: table of PS/2 byte sequences with expected scan results, plus
// hand-written sequences for parity errors, timeout, BAT and reset mid-frame.
module tb_ps2_keyboard_matrix;

  logic clk = 1'b0;
  logic res;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ps2_keyboard_matrix_if bus ();

  ps2_keyboard_matrix #(.TIMEOUT(200)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  typedef struct {
    string          nm;
    int             n;
    logic [0:3][7:0] codes;
    logic [7:0]     pa, pb, epb, epa;
    logic           erst;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h want %02h", nm, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Send one 11-bit frame (or only the first nbits of it).
  task automatic send_frame(input logic [7:0] b, input bit badpar, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ badpar, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = f[i];
      wclk(10);
      bus.ps2_clk = 1'b0;
      wclk(10);
      bus.ps2_clk = 1'b1;
    end
    wclk(10);
    bus.ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  task automatic scan(input logic [7:0] pa, input logic [7:0] pb);
    wclk(10);
    bus.pa_out = pa;
    bus.pb_out = pb;
    wclk(3);
    @(negedge clk);
  endtask

  task automatic chk_all(input string nm, input logic [7:0] epb, input logic [7:0] epa, input logic erst);
    chk({nm, ".pb_in"}, bus.pb_in, epb);
    chk({nm, ".pa_in"}, bus.pa_in, epa);
    chk({nm, ".restore"}, {7'd0, bus.restore}, {7'd0, erst});
  endtask

  initial begin
    vt[0]  = '{"a_make",      1, {8'h1C, 8'h00, 8'h00, 8'h00}, 8'hFD, 8'hFF, 8'hFB, 8'hFF, 1'b0};
    vt[1]  = '{"a_unsel",     0, {8'h00, 8'h00, 8'h00, 8'h00}, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0};
    vt[2]  = '{"a_break",     2, {8'hF0, 8'h1C, 8'h00, 8'h00}, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 1'b0};
    vt[3]  = '{"shift_space", 2, {8'h12, 8'h29, 8'h00, 8'h00}, 8'h7D, 8'hFF, 8'h6F, 8'hFF, 1'b0};
    vt[4]  = '{"reverse",     0, {8'h00, 8'h00, 8'h00, 8'h00}, 8'hFF, 8'hEF, 8'hFF, 8'h7F, 1'b0};
    vt[5]  = '{"rel_two",     4, {8'hF0, 8'h12, 8'hF0, 8'h29}, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b0};
    vt[6]  = '{"restore_on",  2, {8'hE0, 8'h7D, 8'h00, 8'h00}, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b1};
    vt[7]  = '{"restore_off", 3, {8'hE0, 8'hF0, 8'h7D, 8'h00}, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b0};
    vt[8]  = '{"crsr_dn",     2, {8'hE0, 8'h72, 8'h00, 8'h00}, 8'hFE, 8'hFF, 8'h7F, 8'hFF, 1'b0};
    vt[9]  = '{"crsr_dn_rel", 3, {8'hE0, 8'hF0, 8'h72, 8'h00}, 8'hFE, 8'h00, 8'hFF, 8'hFF, 1'b0};
    vt[10] = '{"digit1",      1, {8'h16, 8'h00, 8'h00, 8'h00}, 8'h7F, 8'hFE, 8'hFE, 8'h7F, 1'b0};
    vt[11] = '{"typematic",   4, {8'hF0, 8'h16, 8'h1C, 8'h1C}, 8'hFD, 8'hFB, 8'hFB, 8'hFD, 1'b0};
    vt[12] = '{"fake_shift",  5, {8'hE0, 8'h12, 8'hF0, 8'h1C}, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 1'b0};
    // vt[12] sends E0 12 F0 1C: the unmapped extended code must drop ext so that F0 1C releases A.
    vt[12].n = 4;

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    bus.pa_out   = 8'h00;
    bus.pb_out   = 8'h00;
    res          = 1'b1;
    wclk(2);
    @(negedge clk);
    chk_all("reset", 8'hFF, 8'hFF, 1'b0);
    res = 1'b0;
    bus.pa_out = 8'hFF;
    bus.pb_out = 8'hFF;
    wclk(5);

    for (int i = 0; i < 13; i++) begin
      for (int j = 0; j < vt[i].n; j++) send(vt[i].codes[j]);
      scan(vt[i].pa, vt[i].pb);
      chk_all(vt[i].nm, vt[i].epb, vt[i].epa, vt[i].erst);
    end

    // Bad parity: no key set; a preceding F0 is also dropped, so the next 1C is a make.
    send_frame(8'h1C, 1'b1, 11);
    scan(8'hFD, 8'hFF);
    chk("bad_parity", bus.pb_in, 8'hFF);
    send(8'hF0);
    send_frame(8'h33, 1'b1, 11);
    send(8'h1C);
    scan(8'hFD, 8'hFF);
    chk("err_clears_brk", bus.pb_in, 8'hFB);
    send(8'hF0);
    send(8'h1C);

    // Truncated frame, then idle past the timeout, then a clean Return.
    send_frame(8'h66, 1'b0, 5);
    wclk(250);
    send(8'h5A);
    scan(8'hFE, 8'hFF);
    chk("timeout_recover", bus.pb_in, 8'hFD);

    // BAT with five keys plus RESTORE held.
    send(8'h1C);
    send(8'h12);
    send(8'h29);
    send(8'h16);
    send(8'hE0);
    send(8'h7D);
    scan(8'h00, 8'h00);
    chk_all("five_keys", 8'h68, 8'h7C, 1'b1);
    send(8'hAA);
    scan(8'h00, 8'h00);
    chk_all("bat_clear", 8'hFF, 8'hFF, 1'b0);

    // Reset after bit 4 of a frame; the next full frame must decode cleanly.
    send(8'h1C);
    send_frame(8'h29, 1'b0, 5);
    res = 1'b1;
    wclk(2);
    res = 1'b0;
    scan(8'h00, 8'h00);
    chk_all("reset_mid", 8'hFF, 8'hFF, 1'b0);
    send(8'h1C);
    scan(8'hFD, 8'hFF);
    chk("post_reset_frame", bus.pb_in, 8'hFB);
    scan(8'h7F, 8'hFF);
    chk("post_reset_no_space", bus.pb_in, 8'hFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
